// File: rtl/cic_integ_decim.sv
// rtl/cic_integ_decim.sv - CIC integrator cascade followed by a 1-in-R decimator
module cic_integ_decim #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 42,
    parameter int STAGES    = 3,
    parameter int MAX_R     = 16,
    parameter int RW        = $clog2(MAX_R + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic signed [IN_WIDTH-1:0]  data_in,
    input  logic        [RW-1:0]        dec_ratio,
    output logic signed [ACC_WIDTH-1:0] integ_out,
    output logic                        valid_out,
    output logic        [RW-1:0]        ratio_active
);

    // Running sums; wrap-around is intentional and cancelled by the downstream combs.
    logic [ACC_WIDTH-1:0] acc [STAGES];
    // v[k] marks that acc[k] advanced on the previous edge, so stage k+1 may consume it.
    logic [STAGES-1:0]    v;
    logic [RW-1:0]        cnt;
    logic [RW-1:0]        ratio_clean;
    logic [RW-1:0]        ratio_last;
    logic [ACC_WIDTH-1:0] sample_ext;

    // data_in is signed, so the size cast sign-extends into the accumulator width.
    assign sample_ext = ACC_WIDTH'(data_in);
    assign ratio_last = ratio_active - RW'(1);

    // Clamp the requested ratio into 1..MAX_R.
    always_comb begin
        ratio_clean = dec_ratio;
        if (dec_ratio == '0) begin
            ratio_clean = RW'(1);
        end else if (dec_ratio > RW'(MAX_R)) begin
            ratio_clean = RW'(MAX_R);
        end
    end

    // Integrator cascade: each stage advances only when its upstream stage did.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                acc[k] <= '0;
            end
            v <= '0;
        end else begin
            v[0] <= valid_in;
            for (int k = 1; k < STAGES; k++) begin
                v[k] <= v[k-1];
            end
            if (valid_in) begin
                acc[0] <= acc[0] + sample_ext;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (v[k-1]) begin
                    acc[k] <= acc[k] + acc[k-1];
                end
            end
        end
    end

    // Decimator: emit every ratio_active-th last-stage update; a new ratio is taken only on a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            integ_out    <= '0;
            valid_out    <= 1'b0;
            ratio_active <= ratio_clean;
        end else if (v[STAGES-1]) begin
            if (cnt == ratio_last) begin
                integ_out    <= acc[STAGES-1];
                valid_out    <= 1'b1;
                cnt          <= '0;
                ratio_active <= ratio_clean;
            end else begin
                cnt       <= cnt + RW'(1);
                valid_out <= 1'b0;
            end
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_integ_decim.sv
// tb/tb_cic_integ_decim.sv - scoreboard bench for cic_integ_decim
module tb_cic_integ_decim;

    localparam int S1 = 3;
    localparam int S2 = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic signed [15:0] data_in = '0;
    logic        [4:0]  dec_ratio = 5'd4;
    logic signed [41:0] integ_out;
    logic               valid_out;
    logic        [4:0]  ratio_active;

    logic               valid_in2 = 1'b0;
    logic signed [7:0]  data_in2 = '0;
    logic        [4:0]  dec_ratio2 = 5'd2;
    logic signed [11:0] integ_out2;
    logic               valid_out2;
    logic        [4:0]  ratio_active2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [41:0] val;
        logic [4:0]  ratio;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    cic_integ_decim #(.IN_WIDTH(16), .ACC_WIDTH(42), .STAGES(S1), .MAX_R(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .dec_ratio(dec_ratio),
        .integ_out(integ_out), .valid_out(valid_out), .ratio_active(ratio_active)
    );

    cic_integ_decim #(.IN_WIDTH(8), .ACC_WIDTH(12), .STAGES(S2), .MAX_R(16)) dut_wrap (
        .clk(clk), .rst(rst), .valid_in(valid_in2), .data_in(data_in2), .dec_ratio(dec_ratio2),
        .integ_out(integ_out2), .valid_out(valid_out2), .ratio_active(ratio_active2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int san(input int r);
        if (r == 0) return 1;
        if (r > 16) return 16;
        return r;
    endfunction

    function automatic longint tri_num(input int n);
        return longint'((n + 1) * (n + 2) / 2);
    endfunction

    // Main-DUT monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", cyc, -1);
            end else begin
                e1 = q.pop_front();
                check("integ_out", integ_out, e1.val);
                check("ratio_at_strobe", ratio_active, e1.ratio);
                check("strobe_cycle", cyc, e1.cyc);
            end
        end
    end

    // Wrap-DUT monitor plus a 2-stage modulo-4096 comb that must settle to 127*R*R.
    logic [11:0] w, c_x1 = '0, c_y1 = '0, c_y, c_z;
    int n_out2 = 0;
    always @(negedge clk) begin
        if (valid_out2 === 1'b1) begin
            w = integ_out2;
            if (q2.size() == 0) begin
                check("unexpected_strobe_wrap", cyc, -1);
            end else begin
                e2 = q2.pop_front();
                check("wrap_val", w, e2.val);
                check("wrap_ratio", ratio_active2, e2.ratio);
                check("wrap_cycle", cyc, e2.cyc);
            end
            c_y  = w - c_x1;
            c_z  = c_y - c_y1;
            c_x1 = w;
            c_y1 = c_y;
            if (n_out2 >= 2) check("comb_dc", c_z, 508);
            n_out2++;
        end
    end

    task automatic do_reset(input int r, input bit with_sample);
        @(negedge clk);
        rst       = 1'b1;
        dec_ratio = 5'(r);
        valid_in  = with_sample;
        data_in   = 16'sd5;
        while (q.size() > 0 && q[$].cyc >= cyc + 1) void'(q.pop_back());
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        check("reset_valid_out", valid_out, 0);
        check("reset_integ_out", integ_out, 0);
        check("reset_ratio", ratio_active, san(r));
    endtask

    // Impulse stream; the expected strobe for each closing sample is queued as it is driven.
    task automatic run_imp(input int nsamp, input int r0, input int sw_at, input int r1, input bit bubbles);
        int ra;
        int cnt;
        int cur;
        ra  = san(r0);
        cnt = 0;
        cur = r0;
        for (int n = 0; n < nsamp; n++) begin
            if (bubbles) begin
                @(negedge clk);
                valid_in = 1'b0;
                data_in  = 16'sd7;
            end
            @(negedge clk);
            if (n == sw_at) begin
                dec_ratio = 5'(r1);
                cur       = r1;
            end
            if (sw_at >= 0 && n == sw_at + 2) check("ratio_hold_midperiod", ratio_active, san(r0));
            valid_in = 1'b1;
            data_in  = (n == 0) ? 16'sd1 : 16'sd0;
            if (cnt == ra - 1) begin
                q.push_back('{42'(tri_num(n)), 5'(san(cur)), cyc + 1 + S1});
                cnt = 0;
                ra  = san(cur);
            end else begin
                cnt++;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (q.size() == 0 && q2.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: %0d/%0d strobes still pending after 64 cycles, required 0", q.size(), q2.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int a1;
        int a2;

        // Impulse, R=4: 10, 36, 78, 136
        do_reset(4, 1'b0);
        run_imp(16, 4, -1, 4, 1'b0);
        drain();

        // Same impulse with a bubble before every sample
        do_reset(4, 1'b0);
        run_imp(16, 4, -1, 4, 1'b1);
        drain();

        // R=4 switched to 2 mid-period: strobes at samples 3, 7, 9, 11, 13
        do_reset(4, 1'b0);
        run_imp(14, 4, 7, 2, 1'b0);
        drain();

        // Ratio 0 behaves as 1: a strobe per sample
        do_reset(0, 1'b0);
        run_imp(4, 0, -1, 0, 1'b0);
        drain();

        // Ratio above MAX_R clamps to 16: single strobe at sample 15 (136)
        do_reset(17, 1'b0);
        run_imp(16, 17, -1, 17, 1'b0);
        drain();

        // Reset mid-period with a sample presented in the reset cycle, then a clean rerun
        do_reset(4, 1'b0);
        run_imp(9, 4, -1, 4, 1'b0);
        do_reset(4, 1'b1);
        run_imp(16, 4, -1, 4, 1'b0);
        drain();

        // 12-bit wrap test: DC 127, 2 stages, R=2
        a1 = 0;
        a2 = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            valid_in2 = 1'b1;
            data_in2  = 8'sd127;
            a1 = (a1 + 127) % 4096;
            a2 = (a2 + a1) % 4096;
            if (n % 2 == 1) q2.push_back('{42'(a2), 5'd2, cyc + 1 + S2});
        end
        @(negedge clk);
        valid_in2 = 1'b0;
        data_in2  = '0;
        drain();

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_integ_decim.md
# cic_integ_decim

Integrator-and-decimator front end of the CIC decimation filter: a cascade of `STAGES` running-sum integrators at the input sample rate followed by a 1-in-R downsampler. Its output sample stream and valid strobe feed the comb cascade directly: each comb stage consumes one sample per `valid_out` pulse and uses the same `ACC_WIDTH`. Arithmetic is intentionally modulo 2^`ACC_WIDTH`; wrap-around is cancelled by the downstream combs and is never flagged.

## Interface
- `IN_WIDTH`, 16, signed input sample width
- `ACC_WIDTH`, 42, accumulator/output width; must be ≥ `IN_WIDTH` + `STAGES`·ceil(log2(`MAX_R`·N))
- `STAGES`, 3, number of integrator stages (1..8)
- `MAX_R`, 16, largest supported decimation ratio (≥ 1)
- `RW`, $clog2(`MAX_R`+1), width of the ratio port (derived)

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous and active-high
- `valid_in` in 1: `data_in` is a valid sample this cycle
- `data_in` in `IN_WIDTH`: signed input sample
- `dec_ratio` in `RW`: requested decimation ratio R
- `integ_out` out `ACC_WIDTH`: signed decimated integrator output
- `valid_out` out 1: one-cycle strobe, `integ_out` is valid
- `ratio_active` out `RW`: ratio currently applied

## Operation
- Reset (synchronous, `rst`=1 at a rising edge) clears all accumulators, the valid pipeline, and the phase counter to 0. After reset: `integ_out`=0, `valid_out`=0, `ratio_active`=sanitized `dec_ratio` sampled during reset.
- Ratio sanitization: 0 becomes 1. Values above `MAX_R` become `MAX_R`.
- Stage 1: when `valid_in`, acc1 ← acc1 + sign_extend(`data_in`). Otherwise it holds.
- Stage k (2..`STAGES`): when v[k−1], acc_k ← acc_k + acc_(k−1), using the registered value of acc_(k−1). Otherwise it holds.
- Valid pipeline: v[1] ← `valid_in`; v[k] ← v[k−1]. Bubbles propagate and no stage advances on a bubble.
- Decimator, on v[`STAGES`]:
  - If cnt == `ratio_active`−1: `integ_out` ← acc_`STAGES`, `valid_out` ← 1, cnt ← 0, `ratio_active` ← sanitized `dec_ratio`.
  - Else: cnt ← cnt+1, `valid_out` ← 0.
  - When v[`STAGES`]=0: `valid_out` ← 0, and cnt and `integ_out` hold.
- Ratio changes take effect only at a decimation boundary. A change mid-period never shortens or lengthens the current period.
- Decimation phase: the first valid sample after reset is phase 0. The first output is the integrator state after sample index `ratio_active`−1.
- Overflow wraps two's-complement at every adder. There is no saturation.

## Timing
- Throughput: one input per cycle. `valid_in` may be held high indefinitely.
- Latency: a sample accepted at edge t reaches acc_`STAGES` at edge t+`STAGES`−1. If it closes a period, `valid_out` is asserted after edge t+`STAGES`, i.e. `STAGES`+1 cycles after acceptance.
- `valid_out` is never high for two consecutive cycles when `ratio_active` ≥ 2. With R=1 it follows `valid_in` delayed by `STAGES`+1 cycles.
- `integ_out` holds its last value between strobes.
- Reset mid-operation: in-flight samples are discarded and the phase restarts at 0. `valid_out` is 0 in the cycle after the reset edge.
- Reset and `valid_in` in the same cycle: reset wins and the sample is dropped.

## Test plan
- Impulse, `STAGES`=3, R=4: `data_in`=1 for one valid cycle, then 0 continuously. Required `integ_out` sequence: 10, 36, 78, 136 (values (n+1)(n+2)/2 at n=3,7,11,15). The first strobe arrives 4 cycles after the 4th sample is accepted.
- Bubbles: repeat the impulse test with `valid_in` toggling 1/0. Required: identical output values, each strobe delayed per accepted-sample count, and no strobe emitted on a bubble.
- Ratio change: R=4 with `dec_ratio` switched to 2 after sample 5. Required: the next strobe is at sample 7 (period completes), then strobes follow at samples 9, 11, …. `ratio_active` reads 2 only after the sample-7 strobe.
- Sanitization: `dec_ratio`=0 gives one strobe per sample with `ratio_active`=1. `dec_ratio`=`MAX_R`+1 (when representable) gives `ratio_active`=`MAX_R`.
- Wrap, `ACC_WIDTH`=12, `IN_WIDTH`=8, `STAGES`=2, R=2: DC input 127 for 200 samples. Required: every `integ_out` matches a modulo-4096 golden model, and a downstream 2-stage comb recovers the steady-state value 127·R²=508.
- Reset mid-stream: assert `rst` for 1 cycle during an active period. Required: `valid_out`=0 and `integ_out`=0 afterwards, and the next impulse reproduces the first scenario exactly.
